// File: rtl/maze_map_if.sv
// maze_map_if: shared map read port (request/grant/valid) between move controller and map arbiter
interface maze_map_if #(
    parameter int ADDR_W = 12
);
    logic              map_rd_req;
    logic [ADDR_W-1:0] map_rd_addr;
    logic              map_rd_gnt;
    logic              map_rd_valid;
    logic              map_rd_data;

    modport master (
        output map_rd_req, map_rd_addr,
        input  map_rd_gnt, map_rd_valid, map_rd_data
    );

    modport slave (
        input  map_rd_req, map_rd_addr,
        output map_rd_gnt, map_rd_valid, map_rd_data
    );
endinterface

// File: rtl/maze_move_controller.sv
// maze_move_controller: bounds-checks move pulses, fetches the target wall bit, commits moves and tracks game state
module maze_move_controller #(
    parameter int MAP_W   = 60,
    parameter int MAP_H   = 41,
    parameter int START_X = 0,
    parameter int START_Y = 20,
    parameter int GOAL_X  = 59,
    parameter int GOAL_Y  = 20,
    parameter int ADDR_W  = 12
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  move_pulse,
    maze_map_if.master  map,
    output logic [7:0]  player_x,
    output logic [7:0]  player_y,
    output logic [15:0] move_count,
    output logic [2:0]  state,
    output logic        busy,
    output logic        lost,
    output logic        won
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PLAY = 3'd1;
    localparam logic [2:0] REQ  = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] LOST = 3'd4;
    localparam logic [2:0] WON  = 3'd5;

    logic              req_q, req_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        tx, ty, tx_n, ty_n, px_n, py_n, cx, cy;
    logic [15:0]       cnt_n;
    logic [2:0]        st_n;
    logic              bv, bv_n, use_v, blocked;
    logic [1:0]        bd, bd_n, use_d;

    // Direction code 0=up 1=down 2=left 3=right, lowest set bit wins
    function automatic logic [1:0] prio(input logic [3:0] p);
        return p[0] ? 2'd0 : p[1] ? 2'd1 : p[2] ? 2'd2 : 2'd3;
    endfunction

    assign map.map_rd_req  = req_q;
    assign map.map_rd_addr = addr_q;

    // Candidate target from the buffered direction if present, else from this cycle's pulse
    always_comb begin
        use_v   = bv | (|move_pulse);
        use_d   = bv ? bd : prio(move_pulse);
        blocked = (use_d == 2'd0 && player_y == 8'd0) ||
                  (use_d == 2'd1 && player_y == 8'(MAP_H - 1)) ||
                  (use_d == 2'd2 && player_x == 8'd0) ||
                  (use_d == 2'd3 && player_x == 8'(MAP_W - 1));
        cx      = use_d == 2'd2 ? player_x - 8'd1 : use_d == 2'd3 ? player_x + 8'd1 : player_x;
        cy      = use_d == 2'd0 ? player_y - 8'd1 : use_d == 2'd1 ? player_y + 8'd1 : player_y;
    end

    // Next-state logic for the game FSM, target, pending buffer and committed position
    always_comb begin
        st_n   = state;
        req_n  = req_q;
        addr_n = addr_q;
        tx_n   = tx;
        ty_n   = ty;
        px_n   = player_x;
        py_n   = player_y;
        cnt_n  = move_count;
        bv_n   = bv;
        bd_n   = bd;
        case (state)
            IDLE, LOST, WON: begin
                bv_n = 1'b0;
                if (start) begin
                    st_n  = PLAY;
                    px_n  = 8'(START_X);
                    py_n  = 8'(START_Y);
                    cnt_n = 16'd0;
                end
            end
            PLAY: begin
                bv_n = bv & (|move_pulse);
                bd_n = |move_pulse ? prio(move_pulse) : bd;
                if (use_v && !blocked) begin
                    st_n   = REQ;
                    req_n  = 1'b1;
                    tx_n   = cx;
                    ty_n   = cy;
                    addr_n = ADDR_W'(cy) * ADDR_W'(MAP_W) + ADDR_W'(cx);
                end
            end
            REQ, WAIT: begin
                if (!bv && |move_pulse) begin
                    bv_n = 1'b1;
                    bd_n = prio(move_pulse);
                end
                if (state == REQ && map.map_rd_gnt) begin
                    st_n  = WAIT;
                    req_n = 1'b0;
                end
                if (state == WAIT && map.map_rd_valid) begin
                    if (map.map_rd_data) begin
                        st_n = LOST;
                    end else begin
                        px_n  = tx;
                        py_n  = ty;
                        cnt_n = &move_count ? move_count : move_count + 16'd1;
                        st_n  = (tx == 8'(GOAL_X) && ty == 8'(GOAL_Y)) ? WON : PLAY;
                    end
                end
            end
            default: st_n = IDLE;
        endcase
    end

    // State and outputs registered; Reset drops an outstanding request at once
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            lost       <= 1'b0;
            won        <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            tx         <= 8'd0;
            ty         <= 8'd0;
            player_x   <= 8'(START_X);
            player_y   <= 8'(START_Y);
            move_count <= 16'd0;
            bv         <= 1'b0;
            bd         <= 2'd0;
        end else begin
            state      <= st_n;
            busy       <= st_n == REQ || st_n == WAIT;
            lost       <= st_n == LOST;
            won        <= st_n == WON;
            req_q      <= req_n;
            addr_q     <= addr_n;
            tx         <= tx_n;
            ty         <= ty_n;
            player_x   <= px_n;
            player_y   <= py_n;
            move_count <= cnt_n;
            bv         <= bv_n;
            bd         <= bd_n;
        end
    end
endmodule

// File: tb/tb_maze_move_controller.sv
// tb_maze_move_controller: directed vector and sequence checks for the maze move controller
module tb_maze_move_controller;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  move_pulse = 4'd0;
    logic [7:0]  player_x, player_y;
    logic [15:0] move_count;
    logic [2:0]  state;
    logic        busy, lost, won;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  cur_x, cur_y;

    maze_map_if #(.ADDR_W(12)) m ();

    maze_move_controller dut (
        .clk(clk), .Reset(Reset), .start(start), .move_pulse(move_pulse), .map(m),
        .player_x(player_x), .player_y(player_y), .move_count(move_count),
        .state(state), .busy(busy), .lost(lost), .won(won)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  p;
        int          gd;
        logic        d;
        logic        er;
        logic [11:0] ea;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [15:0] ec;
        logic [2:0]  es;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic do_move(input logic [3:0] p, input int gd, input logic d, input logic er,
                           input logic [11:0] ea, input logic [7:0] ex, input logic [7:0] ey,
                           input logic [15:0] ec, input logic [2:0] es);
        @(negedge clk) move_pulse = p;
        @(negedge clk) move_pulse = 4'd0;
        chk("req", 32'(m.map_rd_req), 32'(er));
        if (er) begin
            chk("addr", 32'(m.map_rd_addr), 32'(ea));
            chk("busy", 32'(busy), 1);
            for (int k = 0; k < gd; k++) begin
                @(negedge clk);
                chk("req_hold", 32'(m.map_rd_req), 1);
                chk("addr_hold", 32'(m.map_rd_addr), 32'(ea));
            end
            m.map_rd_gnt = 1'b1;
            @(negedge clk) m.map_rd_gnt = 1'b0;
            chk("wait_state", 32'(state), 3);
            chk("req_drop", 32'(m.map_rd_req), 0);
            chk("x_before_valid", 32'(player_x), 32'(cur_x));
            m.map_rd_valid = 1'b1;
            m.map_rd_data = d;
            @(negedge clk) m.map_rd_valid = 1'b0;
            m.map_rd_data = 1'b0;
        end else begin
            @(negedge clk);
        end
        chk("x", 32'(player_x), 32'(ex));
        chk("y", 32'(player_y), 32'(ey));
        chk("count", 32'(move_count), 32'(ec));
        chk("state", 32'(state), 32'(es));
        cur_x = ex;
        cur_y = ey;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_state", 32'(state), 1);
        chk("start_x", 32'(player_x), 0);
        chk("start_y", 32'(player_y), 20);
        chk("start_count", 32'(move_count), 0);
        cur_x = 8'd0;
        cur_y = 8'd20;
    endtask

    initial begin
        vecs[0] = '{4'b1000, 0, 1'b0, 1'b1, 12'd1201, 8'd1, 8'd20, 16'd1, 3'd1};
        vecs[1] = '{4'b0100, 0, 1'b0, 1'b1, 12'd1200, 8'd0, 8'd20, 16'd2, 3'd1};
        vecs[2] = '{4'b0100, 0, 1'b0, 1'b0, 12'd0,    8'd0, 8'd20, 16'd2, 3'd1};
        vecs[3] = '{4'b1111, 2, 1'b0, 1'b1, 12'd1140, 8'd0, 8'd19, 16'd3, 3'd1};
        vecs[4] = '{4'b0010, 1, 1'b0, 1'b1, 12'd1200, 8'd0, 8'd20, 16'd4, 3'd1};
        vecs[5] = '{4'b1100, 0, 1'b0, 1'b0, 12'd0,    8'd0, 8'd20, 16'd4, 3'd1};
        vecs[6] = '{4'b1000, 0, 1'b1, 1'b1, 12'd1201, 8'd0, 8'd20, 16'd4, 3'd4};
        m.map_rd_gnt = 1'b0;
        m.map_rd_valid = 1'b0;
        m.map_rd_data = 1'b0;
        cur_x = 8'd0;
        cur_y = 8'd20;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_req", 32'(m.map_rd_req), 0);
        chk("rst_addr", 32'(m.map_rd_addr), 0);
        chk("rst_xy", {16'd0, player_x, player_y}, {16'd0, 8'd0, 8'd20});
        chk("rst_flags", {29'd0, busy, lost, won}, 0);
        Reset = 1'b0;
        @(negedge clk) move_pulse = 4'b1000;
        @(negedge clk) move_pulse = 4'd0;
        chk("idle_ignores_pulse", 32'(state), 0);
        do_start();
        for (int i = 0; i < 7; i++)
            do_move(vecs[i].p, vecs[i].gd, vecs[i].d, vecs[i].er, vecs[i].ea,
                    vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].es);
        chk("lost_flag", 32'(lost), 1);
        @(negedge clk) move_pulse = 4'b1000;
        @(negedge clk) move_pulse = 4'd0;
        @(negedge clk);
        chk("lost_hold", 32'(state), 4);
        chk("lost_no_req", 32'(m.map_rd_req), 0);
        do_start();
        chk("lost_clear", 32'(lost), 0);
        // Pending buffer: down buffered during a withheld grant, later right dropped
        @(negedge clk) move_pulse = 4'b0010;
        @(negedge clk) move_pulse = 4'b0010;
        chk("b_req", 32'(m.map_rd_req), 1);
        chk("b_busy", 32'(busy), 1);
        for (int k = 0; k < 5; k++) begin
            chk("b_addr_hold", 32'(m.map_rd_addr), 1260);
            chk("b_req_hold", 32'(m.map_rd_req), 1);
            @(negedge clk) move_pulse = (k == 0) ? 4'b1000 : 4'd0;
        end
        m.map_rd_gnt = 1'b1;
        @(negedge clk) m.map_rd_gnt = 1'b0;
        m.map_rd_valid = 1'b1;
        @(negedge clk) m.map_rd_valid = 1'b0;
        chk("b_commit_y", 32'(player_y), 21);
        chk("b_commit_state", 32'(state), 1);
        @(negedge clk);
        chk("b_buf_req", 32'(m.map_rd_req), 1);
        chk("b_buf_addr", 32'(m.map_rd_addr), 1320);
        m.map_rd_gnt = 1'b1;
        @(negedge clk) m.map_rd_gnt = 1'b0;
        m.map_rd_valid = 1'b1;
        @(negedge clk) m.map_rd_valid = 1'b0;
        chk("b_y2", 32'(player_y), 22);
        chk("b_count2", 32'(move_count), 2);
        @(negedge clk);
        chk("b_right_dropped", 32'(state), 1);
        cur_y = 8'd22;
        for (int y = 22; y < 40; y++)
            do_move(4'b0010, 0, 1'b0, 1'b1, 12'((y + 1) * 60), 8'd0, 8'(y + 1), 16'(y - 19), 3'd1);
        do_move(4'b0010, 0, 1'b0, 1'b0, 12'd0, 8'd0, 8'd40, 16'd20, 3'd1);
        // Reset while waiting for read data
        @(negedge clk) move_pulse = 4'b1000;
        @(negedge clk) move_pulse = 4'd0;
        m.map_rd_gnt = 1'b1;
        @(negedge clk) m.map_rd_gnt = 1'b0;
        chk("r_wait", 32'(state), 3);
        Reset = 1'b1;
        #1;
        chk("r_state", 32'(state), 0);
        chk("r_req", 32'(m.map_rd_req), 0);
        chk("r_xy", {16'd0, player_x, player_y}, {16'd0, 8'd0, 8'd20});
        chk("r_count", 32'(move_count), 0);
        @(negedge clk) Reset = 1'b0;
        m.map_rd_valid = 1'b1;
        @(negedge clk) m.map_rd_valid = 1'b0;
        @(negedge clk);
        chk("r_late_valid_state", 32'(state), 0);
        chk("r_late_valid_xy", {16'd0, player_x, player_y}, {16'd0, 8'd0, 8'd20});
        // Walk to the goal
        do_start();
        for (int x = 0; x < 59; x++)
            do_move(4'b1000, 0, 1'b0, 1'b1, 12'(1200 + x + 1), 8'(x + 1), 8'd20, 16'(x + 1),
                    (x == 58) ? 3'd5 : 3'd1);
        chk("won_flag", 32'(won), 1);
        chk("won_busy", 32'(busy), 0);
        do_start();
        chk("won_clear", 32'(won), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
